fsm_escritura_rtc: RTL and testbench

- Bus-side controller that consumes the `cambio` flag raised by the button-detect block.
- Runs a continuous read sweep of RTC time registers over a multiplexed address/data bus.
- When `cambio` is set, performs one write transaction of the edited value, then pulses `reset_cambio` back to clear the flag.
- Sits between the edit/button logic and the RTC pins; the display path consumes read results.

---
 rtl/fsm_escritura_rtc_if.sv | 9 +
 rtl/fsm_escritura_rtc.sv | 140 ++++++++++++++
 tb/tb_fsm_escritura_rtc.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fsm_escritura_rtc_if.sv
// fsm_escritura_rtc_if: multiplexed RTC address/data bus between controller and RTC pins
// Signals: cs_n/rd_n/wr_n active-low strobes, a_d (0 address, 1 data),
// ad_out/ad_oe driven bus value and its tri-state enable, ad_in sampled bus value.
interface fsm_escritura_rtc_if;
  logic cs_n, rd_n, wr_n, a_d, ad_oe;
  logic [7:0] ad_out, ad_in;
  modport master(output cs_n, rd_n, wr_n, a_d, ad_oe, ad_out, input ad_in);
  modport slave(input cs_n, rd_n, wr_n, a_d, ad_oe, ad_out, output ad_in);
endinterface

// File: rtl/fsm_escritura_rtc.sv
// fsm_escritura_rtc: RTC bus controller, continuous register read sweep plus on-demand writes
// Ports: clk, rst (async, active-low); cambio/dir_escritura/dato_escritura write request,
// reset_cambio write-complete pulse; bus (RTC pins, master side);
// dato_leido/dir_leida/leido_valid read results; ocupado not-idle; error_escritura sticky readback mismatch.
// Macro ESCRITURA_READBACK_EN: when defined, every write is followed by a verifying read of the same address.
module fsm_escritura_rtc #(
  parameter int PHASE_CYC = 8,
  parameter int GAP_CYC = 4,
  parameter int N_REGS = 3,
  parameter logic [7:0] BASE_ADDR = 8'h21
) (
  input  logic clk,
  input  logic rst,
  input  logic cambio,
  input  logic [7:0] dir_escritura,
  input  logic [7:0] dato_escritura,
  output logic reset_cambio,
  fsm_escritura_rtc_if.master bus,
  output logic [7:0] dato_leido,
  output logic [7:0] dir_leida,
  output logic leido_valid,
  output logic ocupado,
  output logic error_escritura
);
  localparam int CW = $clog2(PHASE_CYC > GAP_CYC ? PHASE_CYC : GAP_CYC) + 1;
  localparam int IW = N_REGS > 1 ? $clog2(N_REGS) : 1;
  typedef enum logic [2:0] {IDLE, ADDR, GAP1, DATA, GAP2, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [7:0] dir, dato, dir_sig;
  logic es_wr, es_rb, escribir, fin_fase, fin_gap;
  assign fin_fase = cnt == CW'(PHASE_CYC - 1);
  assign fin_gap = cnt == CW'(GAP_CYC - 1);
`ifdef ESCRITURA_READBACK_EN
  logic rb_pend;
  // a pending readback outranks a new write request
  assign escribir = cambio && !rb_pend;
  assign dir_sig = rb_pend ? dir : escribir ? dir_escritura : BASE_ADDR + 8'(idx);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rb_pend <= 1'b0;
      es_rb <= 1'b0;
      error_escritura <= 1'b0;
    end else begin
      if (state == IDLE) begin
        rb_pend <= 1'b0;
        es_rb <= rb_pend;
      end else if (state == DONE && es_wr) rb_pend <= 1'b1;
      if (state == DATA && fin_fase && es_rb && bus.ad_in != dato) error_escritura <= 1'b1;
    end
  end
`else
  assign escribir = cambio;
  assign dir_sig = escribir ? dir_escritura : BASE_ADDR + 8'(idx);
  assign es_rb = 1'b0;
  assign error_escritura = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      es_wr <= 1'b0;
      dir <= '0;
      dato <= '0;
      bus.cs_n <= 1'b1;
      bus.rd_n <= 1'b1;
      bus.wr_n <= 1'b1;
      bus.a_d <= 1'b0;
      bus.ad_oe <= 1'b0;
      bus.ad_out <= '0;
      reset_cambio <= 1'b0;
      leido_valid <= 1'b0;
      ocupado <= 1'b0;
      dato_leido <= '0;
      dir_leida <= '0;
    end else begin
      reset_cambio <= 1'b0;
      leido_valid <= 1'b0;
      cnt <= cnt + 1'b1;
      case (state)
        IDLE: begin
          state <= ADDR;
          cnt <= '0;
          ocupado <= 1'b1;
          es_wr <= escribir;
          dir <= dir_sig;
          if (escribir) dato <= dato_escritura;
          bus.cs_n <= 1'b0;
          bus.wr_n <= 1'b0;
          bus.a_d <= 1'b0;
          bus.ad_oe <= 1'b1;
          bus.ad_out <= dir_sig;
        end
        ADDR: if (fin_fase) begin
          state <= GAP1;
          cnt <= '0;
          bus.cs_n <= 1'b1;
          bus.wr_n <= 1'b1;
          bus.ad_oe <= 1'b0;
        end
        GAP1: if (fin_gap) begin
          state <= DATA;
          cnt <= '0;
          bus.cs_n <= 1'b0;
          bus.a_d <= 1'b1;
          bus.wr_n <= !es_wr;
          bus.rd_n <= es_wr;
          bus.ad_oe <= es_wr;
          if (es_wr) bus.ad_out <= dato;
        end
        DATA: if (fin_fase) begin
          state <= GAP2;
          cnt <= '0;
          bus.cs_n <= 1'b1;
          bus.rd_n <= 1'b1;
          bus.wr_n <= 1'b1;
          bus.ad_oe <= 1'b0;
          if (!es_wr) begin
            dato_leido <= bus.ad_in;
            dir_leida <= dir;
          end
          // only sweep reads move the sweep; readbacks leave it in place
          if (!es_wr && !es_rb) idx <= idx == IW'(N_REGS - 1) ? '0 : idx + 1'b1;
        end
        GAP2: if (fin_gap) begin
          state <= DONE;
          reset_cambio <= es_wr;
          leido_valid <= !es_wr;
        end
        DONE: begin
          state <= IDLE;
          ocupado <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fsm_escritura_rtc.sv
// tb_fsm_escritura_rtc: randomized bench with a transaction-offset reference model and an RTC memory model
module tb_fsm_escritura_rtc;
  localparam int P = 8, G = 4, N = 3;
  localparam logic [7:0] BASE = 8'h21;
  localparam int D0 = P + G + 1, LD = 2 * P + G, DN = 2 * P + 2 * G + 1;
`ifdef ESCRITURA_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, cambio = 1'b0;
  logic reset_cambio, leido_valid, ocupado, error_escritura;
  logic [7:0] dir_escritura = 8'h00, dato_escritura = 8'h00, dato_leido, dir_leida;
  fsm_escritura_rtc_if bus();
  fsm_escritura_rtc #(.PHASE_CYC(P), .GAP_CYC(G), .N_REGS(N), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .cambio(cambio), .dir_escritura(dir_escritura),
    .dato_escritura(dato_escritura), .reset_cambio(reset_cambio), .bus(bus),
    .dato_leido(dato_leido), .dir_leida(dir_leida), .leido_valid(leido_valid),
    .ocupado(ocupado), .error_escritura(error_escritura)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic [7:0] mem [256];
  logic [7:0] bus_addr = 8'h00, taddr = 8'h00, tdata = 8'h00, exp_leido = 8'h00, exp_dir = 8'h00;
  int off = 0, typ = 0, midx = 0, hold = 0;
  logic last_ad = 1'b0, err = 1'b0, rb_pend = 1'b0, corrupt = 1'b0;
  logic [7:0] sw_dir [4] = '{8'h21, 8'h22, 8'h23, 8'h21};
  logic [7:0] sw_dat [4] = '{8'h05, 8'h30, 8'h12, 8'h05};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // model: off is the cycle offset inside a transaction (0 = IDLE, DN = DONE); typ 0 read, 1 write, 2 readback
  task automatic ciclo();
    logic ina, ind, w;
    bus.ad_in = mem[bus_addr];
    if (!rst) begin
      off = 0; last_ad = 1'b0; midx = 0; err = 1'b0; rb_pend = 1'b0; exp_leido = 8'h00; exp_dir = 8'h00;
    end else begin
      if (off == 0) begin
        if (rb_pend) begin typ = 2; rb_pend = 1'b0; end
        else if (cambio) begin typ = 1; taddr = dir_escritura; tdata = dato_escritura; end
        else begin typ = 0; taddr = BASE + 8'(midx); end
      end
      if (off == LD && typ != 1) begin
        exp_leido = mem[taddr];
        exp_dir = taddr;
        if (typ == 0) midx = (midx + 1) % N;
        else if (mem[taddr] != tdata) err = 1'b1;
      end
      if (off == DN && typ == 1 && RB) rb_pend = 1'b1;
      if (off == DN) last_ad = 1'b1;
      off = off == DN ? 0 : off + 1;
    end
    @(negedge clk);
    if (!rst) begin
      chk("rst_cs_n", bus.cs_n, 1); chk("rst_rd_n", bus.rd_n, 1); chk("rst_wr_n", bus.wr_n, 1);
      chk("rst_a_d", bus.a_d, 0); chk("rst_ad_oe", bus.ad_oe, 0); chk("rst_ad_out", bus.ad_out, 0);
      chk("rst_reset_cambio", reset_cambio, 0); chk("rst_leido_valid", leido_valid, 0);
      chk("rst_ocupado", ocupado, 0); chk("rst_error", error_escritura, 0);
      chk("rst_dato_leido", dato_leido, 0); chk("rst_dir_leida", dir_leida, 0);
    end else begin
      ina = off >= 1 && off <= P;
      ind = off >= D0 && off <= LD;
      w = typ == 1;
      chk("ocupado", ocupado, off != 0);
      chk("cs_n", bus.cs_n, !(ina || ind));
      chk("wr_n", bus.wr_n, !(ina || (ind && w)));
      chk("rd_n", bus.rd_n, !(ind && !w));
      chk("ad_oe", bus.ad_oe, ina || (ind && w));
      chk("a_d", bus.a_d, off == 0 ? last_ad : off >= D0);
      if (ina) chk("ad_out_addr", bus.ad_out, taddr);
      if (ind && w) chk("ad_out_data", bus.ad_out, tdata);
      chk("reset_cambio", reset_cambio, off == DN && w);
      chk("leido_valid", leido_valid, off == DN && !w);
      if (off == 0 || (off == DN && !w)) begin
        chk("dato_leido", dato_leido, exp_leido);
        chk("dir_leida", dir_leida, exp_dir);
      end
      if (off == 0) chk("error_escritura", error_escritura, err);
    end
    chk("proto_rd_wr", bus.rd_n | bus.wr_n, 1);
    chk("proto_oe_rd", bus.ad_oe & ~bus.rd_n, 0);
    if (!bus.cs_n && !bus.a_d && bus.ad_oe) bus_addr = bus.ad_out;
    if (!bus.cs_n && bus.a_d && !bus.wr_n) mem[bus_addr] = corrupt ? bus.ad_out - 8'd1 : bus.ad_out;
    if (reset_cambio) cambio = 1'b0;
    if (hold > 0) begin cambio = 1'b1; hold--; end
  endtask

  initial begin
    int n;
    bit ok;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h21] = 8'h05; mem[8'h22] = 8'h30; mem[8'h23] = 8'h12;
    bus.ad_in = 8'h00;
    repeat (3) ciclo();
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 4 * (DN + 1); i++) begin
      ciclo();
      if (leido_valid && n < 4) begin
        chk("sweep_dir", dir_leida, sw_dir[n]);
        chk("sweep_dato", dato_leido, sw_dat[n]);
        n++;
      end
    end
    chk("sweep_count", n, 4);
    repeat (7) ciclo();
    dir_escritura = 8'h22; dato_escritura = 8'h45; cambio = 1'b1;
    n = 0;
    for (int i = 0; i < 60; i++) begin ciclo(); n += int'(reset_cambio); end
    chk("mid_read_one_write", n, 1);
    chk("write_stored", mem[8'h22], 8'h45);
    hold = 60;
    n = 0;
    for (int i = 0; i < 120; i++) begin ciclo(); n += int'(reset_cambio); end
    chk("hold_back_to_back", n >= 2, 1);
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 3))
        0: if (!cambio) begin
          dir_escritura = 8'($urandom); dato_escritura = 8'($urandom); cambio = 1'b1;
        end
        1: mem[BASE + 8'($urandom_range(0, N - 1))] = 8'($urandom);
        default: ;
      endcase
      repeat ($urandom_range(1, 40)) ciclo();
    end
    dir_escritura = 8'h22; dato_escritura = 8'h45; cambio = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      ciclo();
      ok = typ == 1 && off == D0 + 2;
    end
    chk("reach_write_data", ok, 1);
    rst = 1'b0;
    #1;
    chk("abort_cs_n", bus.cs_n, 1); chk("abort_rd_n", bus.rd_n, 1);
    chk("abort_wr_n", bus.wr_n, 1); chk("abort_ad_oe", bus.ad_oe, 0);
    repeat (2) ciclo();
    chk("cambio_kept", cambio, 1);
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < DN + 5; i++) begin ciclo(); n += int'(reset_cambio); end
    chk("write_repeated", n, 1);
    repeat (30) ciclo();
    corrupt = RB;
    dir_escritura = 8'h30; dato_escritura = 8'h45; cambio = 1'b1;
    repeat (4 * (DN + 1)) ciclo();
    corrupt = 1'b0;
    chk("readback_error", error_escritura, RB);
    repeat (10) ciclo();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
